// File: rtl/sdm_dac_pkg.sv
// sdm_dac_pkg: shared constants, dither LFSR definition and saturating add
// for the sdm_dac_mod2 second-order delta-sigma modulator.
package sdm_dac_pkg;
    localparam int DIN_WIDTH_DEF = 16;
    localparam int OSR_DEF       = 64;
    localparam int ACC_WIDTH_DEF = DIN_WIDTH_DEF + 4;

    localparam int                LFSR_W    = 15;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 15'h6000;

    typedef struct packed {
        logic               clamped;
        logic signed [63:0] val;
    } sat_res_t;

    // a + b clamped to a w-bit signed range; operands arrive sign-extended to 64 bits
    function automatic sat_res_t sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        sat_res_t r;
        logic signed [63:0] s, hi, lo;
        s = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        r.clamped = (s > hi) || (s < lo);
        r.val = s > hi ? hi : s < lo ? lo : s;
        return r;
    endfunction
endpackage

// File: rtl/sdm_dac_loop.sv
// sdm_dac_loop: two saturating integrators and the 1-bit quantizer.
// Define SDM_DAC_DITHER_EN to add LFSR dither ahead of the quantizer.
module sdm_dac_loop
    import sdm_dac_pkg::*;
#(
    parameter int DIN_WIDTH = DIN_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic signed [DIN_WIDTH-1:0] active,
    output logic                        dout,
    output logic                        sat_hit
);
    localparam logic signed [63:0] FS = 64'sd1 <<< (DIN_WIDTH - 1);

    logic signed [ACC_WIDTH-1:0] i1_q, i1_d, i2_q, i2_d;
    logic                        dout_q, dout_d;
    logic signed [63:0]          fb, dither;
    sat_res_t                    s1, s2;

`ifdef SDM_DAC_DITHER_EN
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = enable ? {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;
        dither = 64'(signed'(lfsr_q[3:0]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign dither = '0;
`endif

    // dither only biases the decision; the integrators never see it
    always_comb begin
        fb      = dout_q ? FS : -FS;
        s1      = sat_add(64'(i1_q), 64'(active) - fb, ACC_WIDTH);
        s2      = sat_add(64'(i2_q), s1.val - fb, ACC_WIDTH);
        i1_d    = enable ? s1.val[ACC_WIDTH-1:0] : '0;
        i2_d    = enable ? s2.val[ACC_WIDTH-1:0] : '0;
        dout_d  = enable && ((s2.val + dither) >= 0);
        sat_hit = enable && (s1.clamped || s2.clamped);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1_q   <= '0;
            i2_q   <= '0;
            dout_q <= 1'b0;
        end else begin
            i1_q   <= i1_d;
            i2_q   <= i2_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
endmodule

// File: rtl/sdm_dac_mod2.sv
// sdm_dac_mod2: second-order delta-sigma DAC modulator with one-entry input buffer,
// OSR zero-order hold and sticky flags. Optional dither: SDM_DAC_DITHER_EN.
module sdm_dac_mod2
    import sdm_dac_pkg::*;
#(
    parameter int DIN_WIDTH = DIN_WIDTH_DEF,
    parameter int OSR       = OSR_DEF,
    parameter int ACC_WIDTH = DIN_WIDTH + 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic signed [DIN_WIDTH-1:0] din,
    input  logic                        din_valid,
    output logic                        din_ready,
    input  logic                        clear_flags,
    output logic                        dout,
    output logic                        sample_tick,
    output logic                        underrun,
    output logic                        sat
);
    localparam int            CW   = $clog2(OSR);
    localparam logic [CW-1:0] LAST = CW'(OSR - 1);

    logic [CW-1:0]               cnt_q, cnt_d;
    logic signed [DIN_WIDTH-1:0] hold_q, hold_d, active_q, active_d;
    logic                        buf_full_q, buf_full_d;
    logic                        sample_tick_q, underrun_q, underrun_d, sat_q, sat_d;
    logic                        tick, xfer, sat_hit;

    // an empty buffer at tick lets a same-cycle transfer bypass straight into active
    always_comb begin
        tick       = enable && cnt_q == LAST;
        din_ready  = !buf_full_q || tick;
        xfer       = din_valid && din_ready;
        cnt_d      = (!enable || tick) ? '0 : cnt_q + 1'b1;
        hold_d     = xfer ? din : hold_q;
        buf_full_d = tick ? (buf_full_q && xfer) : (buf_full_q || xfer);
        active_d   = !enable ? '0 : !tick ? active_q : buf_full_q ? hold_q : xfer ? din : active_q;
        underrun_d = !clear_flags && (underrun_q || (tick && !buf_full_q && !xfer));
        sat_d      = !clear_flags && (sat_q || sat_hit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            hold_q        <= '0;
            active_q      <= '0;
            buf_full_q    <= 1'b0;
            sample_tick_q <= 1'b0;
            underrun_q    <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            active_q      <= active_d;
            buf_full_q    <= buf_full_d;
            sample_tick_q <= tick;
            underrun_q    <= underrun_d;
            sat_q         <= sat_d;
        end
    end

    sdm_dac_loop #(
        .DIN_WIDTH(DIN_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_loop (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .active (active_q),
        .dout   (dout),
        .sat_hit(sat_hit)
    );

    assign sample_tick = sample_tick_q;
    assign underrun    = underrun_q;
    assign sat         = sat_q;
endmodule

// File: tb/tb_sdm_dac_mod2.sv
// tb_sdm_dac_mod2: directed self-checking bench for sdm_dac_mod2 (DIN_WIDTH=16, OSR=64).
// Expectations switch to the dithered variant when SDM_DAC_DITHER_EN is defined.
module tb_sdm_dac_mod2;
    logic              clk = 1'b0, reset = 1'b0, enable = 1'b0, din_valid = 1'b0, clear_flags = 1'b0;
    logic signed [15:0] din = '0;
    logic              din_ready, dout, sample_tick, underrun, sat;
    int                total = 0, bad = 0;

    sdm_dac_mod2 #(.DIN_WIDTH(16), .OSR(64), .ACC_WIDTH(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .clear_flags(clear_flags),
        .dout       (dout),
        .sample_tick(sample_tick),
        .underrun   (underrun),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 200);
    endtask

    task automatic count_ones(input int cycles, output int ones);
        ones = 0;
        repeat (cycles) begin
            @(negedge clk);
            ones += int'(dout);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        total += 5;
        if (dout !== 1'b0) begin bad++; $display("FAIL reset_dout got=%b want=0", dout); end
        if (sample_tick !== 1'b0) begin bad++; $display("FAIL reset_sample_tick got=%b want=0", sample_tick); end
        if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
        if (sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b want=0", sat); end
        if (din_ready !== 1'b1) begin bad++; $display("FAIL reset_din_ready got=%b want=1", din_ready); end
    endtask

    task automatic test_bitstream();
`ifdef SDM_DAC_DITHER_EN
        int exp_bits[4] = '{1, 1, 0, 0};
`else
        int exp_bits[12] = '{1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1};
`endif
        enable = 1'b1;
        din = '0;
        din_valid = 1'b1;
        reset_dut();
        foreach (exp_bits[k]) begin
            @(negedge clk);
            total++;
            if (int'(dout) != exp_bits[k]) begin
                bad++;
                $display("FAIL bitstream[%0d] got=%0d want=%0d", k, dout, exp_bits[k]);
            end
        end
    endtask

    task automatic test_density(input string name, input logic signed [15:0] val, input int cycles, input int want, input int tol);
        int n, ones;
        enable = 1'b1;
        din = val;
        din_valid = 1'b1;
        clear_flags = 1'b0;
        reset_dut();
        wait_tick(n);
        total++;
        if (n != 64) begin bad++; $display("FAIL %s_first_tick got=%0d want=64", name, n); end
        count_ones(cycles, ones);
        total += 3;
        if (ones < want - tol || ones > want + tol) begin
            bad++;
            $display("FAIL %s_ones got=%0d want=%0d+-%0d", name, ones, want, tol);
        end
        if (underrun !== 1'b0) begin bad++; $display("FAIL %s_underrun got=%b want=0", name, underrun); end
        if (sat !== 1'b0) begin bad++; $display("FAIL %s_sat got=%b want=0", name, sat); end
    endtask

    task automatic test_back_to_back();
        int n, lows;
        enable = 1'b1;
        din_valid = 1'b0;
        reset_dut();
        din = 16'sd100;
        din_valid = 1'b1;
        total++;
        if (din_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_empty got=%b want=1", din_ready); end
        @(negedge clk);
        din = 16'sd200;
        lows = 0;
        while (!din_ready && lows < 200) begin
            lows++;
            @(negedge clk);
        end
        total += 2;
        if (lows != 62) begin bad++; $display("FAIL b2b_ready_low_cycles got=%0d want=62", lows); end
        if (sample_tick !== 1'b0) begin bad++; $display("FAIL b2b_pre_tick got=%b want=0", sample_tick); end
        @(negedge clk);
        total += 2;
        if (sample_tick !== 1'b1) begin bad++; $display("FAIL b2b_tick got=%b want=1", sample_tick); end
        if (din_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_captured got=%b want=0", din_ready); end
        din_valid = 1'b0;
        @(negedge clk);
        total++;
        if (sample_tick !== 1'b0) begin bad++; $display("FAIL b2b_tick_pulse got=%b want=0", sample_tick); end
        wait_tick(n);
        total += 3;
        if (n != 63) begin bad++; $display("FAIL b2b_next_tick got=%0d want=63", n); end
        if (din_ready !== 1'b1) begin bad++; $display("FAIL b2b_drained got=%b want=1", din_ready); end
        if (underrun !== 1'b0) begin bad++; $display("FAIL b2b_underrun got=%b want=0", underrun); end
    endtask

    task automatic test_starve();
        int n, ones;
        enable = 1'b1;
        din = 16'sd16384;
        din_valid = 1'b1;
        clear_flags = 1'b0;
        reset_dut();
        @(negedge clk);
        din_valid = 1'b0;
        wait_tick(n);
        total += 2;
        if (n != 63) begin bad++; $display("FAIL starve_first_tick got=%0d want=63", n); end
        if (underrun !== 1'b0) begin bad++; $display("FAIL starve_fed_tick got=%b want=0", underrun); end
        repeat (63) @(negedge clk);
        total++;
        if (underrun !== 1'b0) begin bad++; $display("FAIL starve_before_tick got=%b want=0", underrun); end
        @(negedge clk);
        total += 2;
        if (sample_tick !== 1'b1) begin bad++; $display("FAIL starve_tick got=%b want=1", sample_tick); end
        if (underrun !== 1'b1) begin bad++; $display("FAIL starve_underrun got=%b want=1", underrun); end
        count_ones(1024, ones);
        total++;
        if (ones < 765 || ones > 771) begin bad++; $display("FAIL starve_active_held got=%0d want=768+-3", ones); end
        wait_tick(n);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        total++;
        if (underrun !== 1'b0) begin bad++; $display("FAIL clear_flags got=%b want=0", underrun); end
        repeat (62) @(negedge clk);
        din = -16'sd16384;
        din_valid = 1'b1;
        total++;
        if (din_ready !== 1'b1) begin bad++; $display("FAIL bypass_ready got=%b want=1", din_ready); end
        @(negedge clk);
        din_valid = 1'b0;
        total += 2;
        if (sample_tick !== 1'b1) begin bad++; $display("FAIL bypass_tick got=%b want=1", sample_tick); end
        if (underrun !== 1'b0) begin bad++; $display("FAIL bypass_underrun got=%b want=0", underrun); end
        count_ones(1024, ones);
        total++;
        if (ones < 253 || ones > 259) begin bad++; $display("FAIL bypass_density got=%0d want=256+-3", ones); end
    endtask

    task automatic test_enable();
        int n, ones, ticks;
        enable = 1'b0;
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        total++;
        if (dout !== 1'b0) begin bad++; $display("FAIL idle_dout_cleared got=%b want=0", dout); end
        ones = 0;
        ticks = 0;
        repeat (100) begin
            @(negedge clk);
            ones += int'(dout);
            ticks += int'(sample_tick);
        end
        total += 3;
        if (ones != 0) begin bad++; $display("FAIL idle_ones got=%0d want=0", ones); end
        if (ticks != 0) begin bad++; $display("FAIL idle_ticks got=%0d want=0", ticks); end
        if (underrun !== 1'b0) begin bad++; $display("FAIL idle_underrun got=%b want=0", underrun); end
        din = 16'sd5;
        din_valid = 1'b1;
        total++;
        if (din_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", din_ready); end
        @(negedge clk);
        din_valid = 1'b0;
        total++;
        if (din_ready !== 1'b0) begin bad++; $display("FAIL idle_buffered got=%b want=0", din_ready); end
        enable = 1'b1;
        wait_tick(n);
        total += 3;
        if (n != 64) begin bad++; $display("FAIL reenable_tick got=%0d want=64", n); end
        if (underrun !== 1'b0) begin bad++; $display("FAIL reenable_underrun got=%b want=0", underrun); end
        if (din_ready !== 1'b1) begin bad++; $display("FAIL reenable_drained got=%b want=1", din_ready); end
    endtask

    task automatic test_sat_reset();
        int n, ones;
        enable = 1'b1;
        din = 16'sd32767;
        din_valid = 1'b1;
        clear_flags = 1'b0;
        reset_dut();
        repeat (3072) @(negedge clk);
        count_ones(1024, ones);
        total += 3;
        if (ones < 1016) begin bad++; $display("FAIL fullscale_ones got=%0d want>=1016", ones); end
        if (sat !== 1'b1) begin bad++; $display("FAIL fullscale_sat got=%b want=1", sat); end
        if (underrun !== 1'b0) begin bad++; $display("FAIL fullscale_underrun got=%b want=0", underrun); end
        #2 reset = 1'b1;
        #1;
        total += 5;
        if (dout !== 1'b0) begin bad++; $display("FAIL midreset_dout got=%b want=0", dout); end
        if (sample_tick !== 1'b0) begin bad++; $display("FAIL midreset_sample_tick got=%b want=0", sample_tick); end
        if (underrun !== 1'b0) begin bad++; $display("FAIL midreset_underrun got=%b want=0", underrun); end
        if (sat !== 1'b0) begin bad++; $display("FAIL midreset_sat got=%b want=0", sat); end
        if (din_ready !== 1'b1) begin bad++; $display("FAIL midreset_din_ready got=%b want=1", din_ready); end
        @(negedge clk);
        reset = 1'b0;
        wait_tick(n);
        total++;
        if (n != 64) begin bad++; $display("FAIL midreset_first_tick got=%0d want=64", n); end
    endtask

    initial begin
        test_reset();
        test_bitstream();
`ifdef SDM_DAC_DITHER_EN
        test_density("zero", 16'sd0, 8192, 4096, 82);
`else
        test_density("zero", 16'sd0, 1024, 512, 2);
`endif
        test_density("half_pos", 16'sd16384, 1024, 768, 3);
        test_density("half_neg", -16'sd16384, 1024, 256, 3);
        test_back_to_back();
        test_starve();
        test_enable();
        test_sat_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
